// File: rtl/class_vote_filter.sv
// -----------------------------------------------------------------------------
// class_vote_filter
//
// Temporal vote filter placed after the 24-class winner-select tree. It takes
// one (winning index, winning score) result per classified frame. A letter is
// reported only after STABLE_CNT consecutive matching frames have been seen.
// A locked letter survives short runs of misclassification. The lock is
// released after TIMEOUT_CYC cycles pass with no accepted frame.
//
// Optional feature macro: CONF_GATE_EN
//   defined   : a frame is rejected when data_i < thresh_i (unsigned compare)
//   undefined : data_i and thresh_i are ignored
//
// Ports
//   clk            in   1           system clock, rising edge
//   resetn         in   1           asynchronous active-low reset
//   data_i         in   DATA_WIDTH  winning score of the frame (unsigned)
//   idx_i          in   5           winning class index
//   valid_i        in   1           one-cycle strobe, data_i/idx_i valid
//   thresh_i       in   DATA_WIDTH  confidence threshold (CONF_GATE_EN only)
//   clear_i        in   1           synchronous flush to IDLE
//   class_o        out  5           stable (locked) class index
//   class_valid_o  out  1           class_o holds a locked letter
//   change_o       out  1           one-cycle pulse when class_o gets a new lock
//   state_o        out  2           0 IDLE, 1 TRACK, 2 LOCKED, 3 SWITCH
// -----------------------------------------------------------------------------
module class_vote_filter #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASS   = 24,
    parameter int STABLE_CNT  = 4,
    parameter int TIMEOUT_W   = 24,
    parameter int TIMEOUT_CYC = (1 << 24) - 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [4:0]            idx_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] thresh_i,
    input  logic                  clear_i,
    output logic [4:0]            class_o,
    output logic                  class_valid_o,
    output logic                  change_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

    localparam logic [3:0]           C_STABLE   = 4'(STABLE_CNT);
    localparam logic [5:0]           C_NUM_CLS  = 6'(NUM_CLASS);
    localparam logic [TIMEOUT_W-1:0] C_TMO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] C_TMO_MAX  = '1;

    // Registered state
    state_t               r_state;
    logic [4:0]           r_cand;
    logic [3:0]           r_run;
    logic [TIMEOUT_W-1:0] r_tmo;
    logic [4:0]           r_class;
    logic                 r_class_valid;
    logic                 r_change;

    // Next-state values
    state_t               w_state_next;
    logic [4:0]           w_cand_next;
    logic [3:0]           w_run_next;
    logic [TIMEOUT_W-1:0] w_tmo_next;
    logic [4:0]           w_class_next;
    logic                 w_class_valid_next;
    logic                 w_change_next;

    // Frame qualification
    logic                 w_gate_pass;
    logic                 w_idx_ok;
    logic                 w_accept;
    logic                 w_timeout;
    logic [TIMEOUT_W-1:0] w_tmo_inc;
    logic                 w_same_cand;
    logic [3:0]           w_cand_run;

`ifdef CONF_GATE_EN
    assign w_gate_pass = (data_i >= thresh_i);
`else
    // Score and threshold are deliberately ignored in this build.
    logic w_unused_gate;
    assign w_unused_gate = &{1'b0, data_i, thresh_i};
    assign w_gate_pass   = 1'b1;
`endif

    assign w_idx_ok  = ({1'b0, idx_i} < C_NUM_CLS);
    assign w_accept  = valid_i & w_idx_ok & w_gate_pass;
    assign w_tmo_inc = (r_tmo == C_TMO_MAX) ? r_tmo : r_tmo + 1'b1;
    assign w_timeout = (r_state != ST_IDLE) && (r_tmo == C_TMO_LAST);

    // A frame extends the current run only while a candidate is being counted
    // (TRACK/SWITCH); in IDLE/LOCKED any non-matching frame starts a new run.
    assign w_same_cand = ((r_state == ST_TRACK) || (r_state == ST_SWITCH)) &&
                         (idx_i == r_cand);
    assign w_cand_run  = w_same_cand ? (r_run + 4'd1) : 4'd1;

    always_comb begin
        w_state_next       = r_state;
        w_cand_next        = r_cand;
        w_run_next         = r_run;
        w_tmo_next         = w_accept ? '0 : w_tmo_inc;
        w_class_next       = r_class;
        w_class_valid_next = r_class_valid;
        w_change_next      = 1'b0;

        if (clear_i) begin
            w_state_next       = ST_IDLE;
            w_class_valid_next = 1'b0;
            w_run_next         = 4'd0;
            w_tmo_next         = '0;
        end else if (w_timeout) begin
            // class_o is left at its last value; only the valid flag drops.
            w_state_next       = ST_IDLE;
            w_class_valid_next = 1'b0;
            w_run_next         = 4'd0;
        end else if (w_accept) begin
            if ((r_state == ST_LOCKED) && (idx_i == r_class)) begin
                w_state_next = ST_LOCKED;
            end else if ((r_state == ST_SWITCH) && (idx_i == r_class)) begin
                // Locked letter reappeared: abandon the challenger.
                w_state_next = ST_LOCKED;
                w_run_next   = 4'd0;
            end else if (w_cand_run == C_STABLE) begin
                // Lock or switch. The candidate can never equal the locked
                // letter here, so this is always a new locked value.
                w_state_next       = ST_LOCKED;
                w_class_next       = idx_i;
                w_class_valid_next = 1'b1;
                w_change_next      = 1'b1;
                w_cand_next        = idx_i;
                w_run_next         = 4'd0;
            end else begin
                w_cand_next  = idx_i;
                w_run_next   = w_cand_run;
                w_state_next = r_class_valid ? ST_SWITCH : ST_TRACK;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_cand        <= 5'd0;
            r_run         <= 4'd0;
            r_tmo         <= '0;
            r_class       <= 5'd0;
            r_class_valid <= 1'b0;
            r_change      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cand        <= w_cand_next;
            r_run         <= w_run_next;
            r_tmo         <= w_tmo_next;
            r_class       <= w_class_next;
            r_class_valid <= w_class_valid_next;
            r_change      <= w_change_next;
        end
    end

    assign class_o       = r_class;
    assign class_valid_o = r_class_valid;
    assign change_o      = r_change;
    assign state_o       = r_state;

endmodule

// File: tb/tb_class_vote_filter.sv
module tb_class_vote_filter;

    localparam int DW = 16;
    localparam int NC = 24;
    localparam int SC = 4;
    localparam int TW = 24;
    localparam int TC = 16;

    logic          clk      = 1'b0;
    logic          resetn   = 1'b0;
    logic [DW-1:0] data_i   = '0;
    logic [4:0]    idx_i    = '0;
    logic          valid_i  = 1'b0;
    logic [DW-1:0] thresh_i = '0;
    logic          clear_i  = 1'b0;
    logic [4:0]    class_o;
    logic          class_valid_o;
    logic          change_o;
    logic [1:0]    state_o;

    int total = 0;
    int bad   = 0;

    class_vote_filter #(
        .DATA_WIDTH (DW),
        .NUM_CLASS  (NC),
        .STABLE_CNT (SC),
        .TIMEOUT_W  (TW),
        .TIMEOUT_CYC(TC)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .data_i       (data_i),
        .idx_i        (idx_i),
        .valid_i      (valid_i),
        .thresh_i     (thresh_i),
        .clear_i      (clear_i),
        .class_o      (class_o),
        .class_valid_o(class_valid_o),
        .change_o     (change_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: remembers the history of accepted indices since the
    // last flush, the locked letter, and the number of idle cycles.
    // ------------------------------------------------------------------
    int m_hist[$];
    int m_letter = 0;
    bit m_valid  = 0;
    bit m_change = 0;
    bit m_idle   = 1;
    int m_last   = 0;
    int m_tmo    = 0;

    function automatic int trailing_run();
        int n = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] == m_hist[m_hist.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    function automatic int exp_state();
        if (m_idle) return 0;
        if (!m_valid) return 1;
        return (m_last == m_letter) ? 2 : 3;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_hist.delete();
            m_letter = 0;
            m_valid  = 0;
            m_change = 0;
            m_idle   = 1;
            m_last   = 0;
            m_tmo    = 0;
        end else begin
            bit acc;
            int next_tmo;
            acc = valid_i && (int'(idx_i) < NC);
`ifdef CONF_GATE_EN
            acc = acc && (data_i >= thresh_i);
`endif
            next_tmo = acc ? 0 : ((m_tmo == (2**TW) - 1) ? m_tmo : m_tmo + 1);
            m_change = 0;
            if (clear_i) begin
                m_idle  = 1;
                m_valid = 0;
                m_hist.delete();
                m_tmo   = 0;
            end else if (!m_idle && m_tmo == TC - 1) begin
                m_idle  = 1;
                m_valid = 0;
                m_hist.delete();
                m_tmo   = next_tmo;
            end else begin
                m_tmo = next_tmo;
                if (acc) begin
                    m_idle = 0;
                    m_last = int'(idx_i);
                    m_hist.push_back(int'(idx_i));
                    if (m_hist.size() > 16) void'(m_hist.pop_front());
                    if (trailing_run() == SC && (!m_valid || m_last != m_letter)) begin
                        m_letter = m_last;
                        m_valid  = 1;
                        m_change = 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_class", class_o, m_letter);
        chk("model_valid", class_valid_o, m_valid);
        chk("model_change", change_o, m_change);
        chk("model_state", state_o, exp_state());
    end

    task automatic step(input bit v, input int idx, input bit clr = 1'b0, input int d = 32'h0000FFFF);
        valid_i = v;
        idx_i   = idx[4:0];
        clear_i = clr;
        data_i  = d[DW-1:0];
        @(negedge clk);
        valid_i = 1'b0;
        clear_i = 1'b0;
        $display("step valid=%0d idx=%0d clr=%0d -> class=%0d cv=%0d chg=%0d st=%0d",
                 v, idx, clr, class_o, class_valid_o, change_o, state_o);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_class", class_o, 0);
        chk("rst_valid", class_valid_o, 0);
        chk("rst_change", change_o, 0);
        chk("rst_state", state_o, 0);
        resetn = 1'b1;
        step(0, 0);

        // Lock on 7
        step(1, 7);
        chk("t2_track", state_o, 1);
        step(1, 7);
        step(1, 7);
        chk("t2_not_yet", class_valid_o, 0);
        step(1, 7);
        chk("t2_class", class_o, 7);
        chk("t2_valid", class_valid_o, 1);
        chk("t2_change", change_o, 1);
        chk("t2_locked", state_o, 2);
        step(0, 0);
        chk("t2_change_drop", change_o, 0);

        // Challenger 3 interrupted by 7, then four 3s switch
        step(1, 3);
        chk("t3_switch", state_o, 3);
        step(1, 3);
        chk("t3_hold", class_o, 7);
        step(1, 7);
        chk("t3_back", state_o, 2);
        step(1, 3);
        step(1, 3);
        step(1, 3);
        chk("t3_still7", class_o, 7);
        step(1, 3);
        chk("t3_class", class_o, 3);
        chk("t3_change", change_o, 1);

        // Out-of-range indices ignored while locked
        step(1, 24);
        step(1, 31);
        chk("t4_state", state_o, 2);
        chk("t4_class", class_o, 3);

        // Clear and clear+valid in TRACK
        step(0, 0, 1);
        chk("t6_clear_state", state_o, 0);
        chk("t6_clear_valid", class_valid_o, 0);
        step(1, 9);
        step(1, 9);
        chk("t6_track", state_o, 1);
        step(1, 9, 1);
        chk("t6_discard", state_o, 0);
        step(1, 9);
        step(1, 24);
        step(1, 9);
        step(1, 31);
        step(1, 9);
        chk("t4_run_kept", class_valid_o, 0);
        step(1, 9);
        chk("t4_lock9", class_o, 9);
        chk("t4_lock9_chg", change_o, 1);

        // Timeout after lock on 5
        repeat (4) step(1, 5);
        chk("t5_lock", class_o, 5);
        repeat (4) step(0, 0);
        step(1, 31);
        repeat (10) step(0, 0);
        chk("t5_before", class_valid_o, 1);
        step(0, 0);
        chk("t5_valid", class_valid_o, 0);
        chk("t5_state", state_o, 0);
        chk("t5_class", class_o, 5);
        chk("t5_nochg", change_o, 0);

        // Asynchronous reset mid-stream
        step(1, 2);
        step(1, 2);
        chk("t1_pre", state_o, 1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("t1_class", class_o, 0);
        chk("t1_valid", class_valid_o, 0);
        chk("t1_change", change_o, 0);
        chk("t1_state", state_o, 0);
        @(negedge clk);
        resetn = 1'b1;
        step(0, 0);

        // Confidence gate
        thresh_i = 16'h0100;
`ifdef CONF_GATE_EN
        step(1, 11, 0, 32'h00FF);
        chk("gate_reject", state_o, 0);
        step(1, 11, 0, 32'h0100);
        chk("gate_accept", state_o, 1);
`else
        step(1, 11, 0, 32'h0000);
        chk("nogate_accept", state_o, 1);
`endif
        step(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
